round_judge: RTL and testbench

Per-round reaction judge for the two-player game. It runs a round on a `startRound` pulse: an arm delay, then a lit response window. It classifies each player's first button press into a 2-bit result code. It then issues a one-cycle `startCalc` pulse with both codes to the downstream score accumulator, so it is the producer side of the `b1`/`b2`/`startCalc` scoring interface.

---
 rtl/game_pkg.sv | 20 ++
 rtl/press_capture.sv | 46 ++++
 rtl/round_judge.sv | 94 +++++++++
 tb/tb_round_judge.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the reaction game: FSM states and the per-player result codes
// exchanged with the score accumulator.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        WINDOW,
        REPORT
    } state_t;

    localparam logic [1:0] CODE_MISS = 2'd0;
    localparam logic [1:0] CODE_HIT  = 2'd1;
    localparam logic [1:0] CODE_FAST = 2'd2;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/press_capture.sv
// Per-player rising-edge detector with a first-press latch and FAST/HIT classification.
module press_capture
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       button,
    input  logic       window,
    input  logic       clear,
    input  logic       fast,
    output logic       captured,
    output logic [1:0] code
);

    logic       prev;
    logic       cap_q;
    logic [1:0] code_q;
    logic       press;
    logic [1:0] press_code;

    assign press      = window & button & ~prev & ~cap_q;
    assign press_code = fast ? CODE_FAST : CODE_HIT;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev   <= 1'b0;
            cap_q  <= 1'b0;
            code_q <= CODE_MISS;
        end else begin
            prev <= button;
            if (clear) begin
                cap_q  <= 1'b0;
                code_q <= CODE_MISS;
            end else if (press) begin
                cap_q  <= 1'b1;
                code_q <= press_code;
            end
        end
    end

    // Look-ahead view: includes a capture happening on this edge so the FSM can leave
    // the window and load the report registers on the same edge.
    assign captured = cap_q | press;
    assign code     = press ? press_code : code_q;

endmodule

// File: rtl/round_judge.sv
// Round sequencer: arm delay, lit response window, then a one-cycle startCalc report of
// both players' result codes to the score accumulator.
module round_judge
    import game_pkg::*;
#(
    parameter int unsigned ARM_CYCLES    = 50,
    parameter int unsigned WINDOW_CYCLES = 100,
    parameter int unsigned FAST_CYCLES   = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       startRound,
    input  logic       p1,
    input  logic       p2,
    output logic       go,
    output logic       busy,
    output logic [1:0] b1,
    output logic [1:0] b2,
    output logic       startCalc
);

    localparam int unsigned CW = $clog2(max_u(ARM_CYCLES, WINDOW_CYCLES) + 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          clear, window, fast;
    logic          cap1, cap2;
    logic [1:0]    code1, code2;

    assign clear  = (state == IDLE) & startRound;
    assign window = (state == WINDOW);
    assign fast   = (cnt < CW'(FAST_CYCLES));

    press_capture u_cap1 (
        .clk      (clk),
        .rst      (rst),
        .button   (p1),
        .window   (window),
        .clear    (clear),
        .fast     (fast),
        .captured (cap1),
        .code     (code1)
    );

    press_capture u_cap2 (
        .clk      (clk),
        .rst      (rst),
        .button   (p2),
        .window   (window),
        .clear    (clear),
        .fast     (fast),
        .captured (cap2),
        .code     (code2)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (startRound) state_nxt = ARM;
            ARM:     if (cnt == CW'(ARM_CYCLES - 1)) state_nxt = WINDOW;
            WINDOW:  if ((cap1 && cap2) || cnt == CW'(WINDOW_CYCLES - 1)) state_nxt = REPORT;
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One counter serves ARM and WINDOW; it restarts from zero on every state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            b1  <= CODE_MISS;
            b2  <= CODE_MISS;
        end else begin
            if (state_nxt != state)
                cnt <= '0;
            else if (state == ARM || state == WINDOW)
                cnt <= cnt + CW'(1);
            if (state == WINDOW && state_nxt == REPORT) begin
                b1 <= code1;
                b2 <= code2;
            end
        end
    end

    assign go        = (state == WINDOW);
    assign busy      = (state != IDLE);
    assign startCalc = (state == REPORT);

endmodule

// File: tb/tb_round_judge.sv
// Bench for round_judge: fixed scenario table, reset abort sequence and random rounds
// checked against a window-index reference model.
module tb_round_judge;
    import game_pkg::*;

    localparam int ARMC  = 4;
    localparam int WINC  = 10;
    localparam int FASTC = 3;
    localparam int SPAN  = ARMC + WINC;

    logic       clk = 1'b0;
    logic       rst;
    logic       startRound;
    logic       p1, p2;
    logic       go, busy, startCalc;
    logic [1:0] b1, b2;

    int checks = 0;
    int errors = 0;
    logic [1:0] ob1 = 2'd0, ob2 = 2'd0;

    round_judge #(
        .ARM_CYCLES    (ARMC),
        .WINDOW_CYCLES (WINC),
        .FAST_CYCLES   (FASTC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .startRound (startRound),
        .p1         (p1),
        .p2         (p2),
        .go         (go),
        .busy       (busy),
        .b1         (b1),
        .b2         (b2),
        .startCalc  (startCalc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         k1;
        int         k1b;
        int         k2;
        bit         hold1;
        bit         arm2;
        logic [1:0] e1;
        logic [1:0] e2;
        int         rep;
    } vec_t;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: scan window indices for each player's first rising edge; the round
    // reports one slot after both are captured, or after the last window index.
    function automatic void model(input logic [SPAN-1:0] l1, input logic [SPAN-1:0] l2,
                                  output logic [1:0] e1, output logic [1:0] e2, output int rep);
        bit c1, c2;
        c1 = 0; c2 = 0; e1 = 2'd0; e2 = 2'd0; rep = WINC;
        for (int k = 0; k < WINC; k++) begin
            int j;
            j = ARMC + k;
            if (!c1 && l1[j] && !l1[j-1]) begin c1 = 1; e1 = (k < FASTC) ? 2'd2 : 2'd1; end
            if (!c2 && l2[j] && !l2[j-1]) begin c2 = 1; e2 = (k < FASTC) ? 2'd2 : 2'd1; end
            if (c1 && c2) begin rep = k + 1; break; end
        end
    endfunction

    task automatic run_round(input logic [SPAN-1:0] lv1, input logic [SPAN-1:0] lv2,
                             input logic pv1, input logic pv2, input logic noise,
                             input logic [1:0] e1, input logic [1:0] e2, input int rep);
        logic go_e, sc_e;
        @(negedge clk);
        startRound = 1'b1; p1 = pv1; p2 = pv2;
        for (int j = 0; j <= ARMC + rep; j++) begin
            @(negedge clk);
            go_e = (j >= ARMC) && (j < ARMC + rep);
            sc_e = (j == ARMC + rep);
            chk("ctl", 8'({go, busy, startCalc}), 8'({go_e, 1'b1, sc_e}));
            if (sc_e) chk("codes", 8'({b1, b2}), 8'({e1, e2}));
            else      chk("bhold", 8'({b1, b2}), 8'({ob1, ob2}));
            startRound = noise;
            p1 = (j < SPAN) ? lv1[j] : 1'b0;
            p2 = (j < SPAN) ? lv2[j] : 1'b0;
        end
        @(negedge clk);
        chk("idle", 8'({go, busy, startCalc}), 8'd0);
        chk("after", 8'({b1, b2}), 8'({e1, e2}));
        startRound = 1'b0;
        ob1 = e1; ob2 = e2;
    endtask

    vec_t vecs[10];

    initial begin
        logic [SPAN-1:0] l1, l2;
        logic [1:0]      m1, m2;
        int              mrep;
        logic            cur1, cur2, pv1, pv2;

        vecs[0] = '{-1, -1, -1, 0, 0, 2'd0, 2'd0, 10};
        vecs[1] = '{ 1, -1,  5, 0, 0, 2'd2, 2'd1,  6};
        vecs[2] = '{ 4, -1,  4, 0, 0, 2'd1, 2'd1,  5};
        vecs[3] = '{ 2, -1, -1, 0, 0, 2'd2, 2'd0, 10};
        vecs[4] = '{-1, -1, -1, 1, 1, 2'd0, 2'd0, 10};
        vecs[5] = '{ 1,  5, -1, 0, 0, 2'd2, 2'd0, 10};
        vecs[6] = '{ 0, -1,  0, 0, 0, 2'd2, 2'd2,  1};
        vecs[7] = '{-1, -1,  9, 0, 0, 2'd0, 2'd1, 10};
        vecs[8] = '{ 2, -1,  3, 0, 0, 2'd2, 2'd1,  4};
        vecs[9] = '{ 9, -1,  9, 0, 0, 2'd1, 2'd1, 10};

        rst = 1'b0; startRound = 1'b0; p1 = 1'b0; p2 = 1'b0;
        #1;
        chk("reset", 8'({go, busy, startCalc, b1, b2}), 8'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int v = 0; v < 10; v++) begin
            for (int j = 0; j < SPAN; j++) begin
                l1[j] = vecs[v].hold1 ||
                        (vecs[v].k1  >= 0 && j == ARMC + vecs[v].k1) ||
                        (vecs[v].k1b >= 0 && j == ARMC + vecs[v].k1b);
                l2[j] = (vecs[v].arm2 && j < ARMC && (j % 2 == 0)) ||
                        (vecs[v].k2 >= 0 && j == ARMC + vecs[v].k2);
            end
            run_round(l1, l2, 1'b0, 1'b0, v[0], vecs[v].e1, vecs[v].e2, vecs[v].rep);
        end

        // Abort a round with reset at window index 3; no report may follow.
        @(negedge clk);
        startRound = 1'b1;
        @(negedge clk);
        startRound = 1'b0;
        repeat (ARMC + 3) @(negedge clk);
        chk("pre_abort", 8'({go, busy}), 8'h3);
        rst = 1'b0;
        #1;
        chk("abort", 8'({go, busy, startCalc, b1, b2}), 8'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("no_report", 8'({busy, startCalc}), 8'd0);
        end
        ob1 = 2'd0; ob2 = 2'd0;

        for (int r = 0; r < 40; r++) begin
            pv1 = 1'($urandom_range(0, 1));
            pv2 = 1'($urandom_range(0, 1));
            cur1 = pv1; cur2 = pv2;
            for (int j = 0; j < SPAN; j++) begin
                if ($urandom_range(0, 4) == 0) cur1 = ~cur1;
                if ($urandom_range(0, 4) == 0) cur2 = ~cur2;
                l1[j] = cur1; l2[j] = cur2;
            end
            model(l1, l2, m1, m2, mrep);
            run_round(l1, l2, pv1, pv2, 1'($urandom_range(0, 1)), m1, m2, mrep);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
